// File: rtl/parking_ctrl_gen_if.sv
// Request/response bundle between the entry/exit pulse logic and the parking controller core.
// PARK_STATS_EN adds the statistics outputs total_entries and peak_occupancy.
interface parking_ctrl_gen_if #(
  parameter int NUM_SPOTS = 4,
  parameter int DUR_W     = 12
);
  localparam int IDX_W = $clog2(NUM_SPOTS);
  localparam int CAP_W = $clog2(NUM_SPOTS + 1);

  logic                 tick;
  logic                 entry_req;
  logic                 exit_req;
  logic [IDX_W-1:0]     exit_slot;
  logic [NUM_SPOTS-1:0] spots;
  logic [CAP_W-1:0]     capacity;
  logic [IDX_W-1:0]     location;
  logic                 is_full;
  logic                 is_open;
  logic                 entry_ack;
  logic [IDX_W-1:0]     entry_slot;
  logic                 entry_reject;
  logic                 exit_ack;
  logic                 exit_err;
  logic [DUR_W-1:0]     exit_duration;
`ifdef PARK_STATS_EN
  logic [15:0]          total_entries;
  logic [CAP_W-1:0]     peak_occupancy;
`endif

  modport master (
    output tick, entry_req, exit_req, exit_slot,
    input  spots, capacity, location, is_full, is_open,
    input  entry_ack, entry_slot, entry_reject, exit_ack, exit_err, exit_duration
`ifdef PARK_STATS_EN
    , input total_entries, peak_occupancy
`endif
  );

  modport slave (
    input  tick, entry_req, exit_req, exit_slot,
    output spots, capacity, location, is_full, is_open,
    output entry_ack, entry_slot, entry_reject, exit_ack, exit_err, exit_duration
`ifdef PARK_STATS_EN
    , output total_entries, peak_occupancy
`endif
  );
endinterface

// File: rtl/parking_ctrl_gen.sv
// Parametrised parking-lot controller: lowest-free allocation, per-spot duration timers, timed door.
// Optional macro PARK_STATS_EN adds total_entries / peak_occupancy counters.

// Per-spot saturating duration timer; cleared whenever the spot is (or becomes) free or is newly allocated.
module parking_spot_timer #(
  parameter int DUR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             keep,
  input  logic             clr,
  output logic [DUR_W-1:0] dur
);
  always_ff @(posedge clk) begin
    if (reset || !keep || clr) dur <= '0;
    else if (tick && dur != {DUR_W{1'b1}}) dur <= dur + DUR_W'(1);
  end
endmodule

module parking_ctrl_gen #(
  parameter int NUM_SPOTS = 4,
  parameter int DUR_W     = 12,
  parameter int DOOR_HOLD = 3
) (
  input  logic           clk,
  input  logic           reset,
  parking_ctrl_gen_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_SPOTS);
  localparam int CAP_W  = $clog2(NUM_SPOTS + 1);
  localparam int HOLD_W = $clog2(DOOR_HOLD + 1);
  localparam logic [0:0] CLOSED = 1'b0;
  localparam logic [0:0] OPEN   = 1'b1;

  logic [NUM_SPOTS-1:0]            occ, occ_nxt, alloc, rel;
  logic [NUM_SPOTS-1:0][DUR_W-1:0] dur;
  logic [IDX_W-1:0]                free_idx, loc_nxt, entry_slot_r, loc_r;
  logic [CAP_W-1:0]                free_cnt_nxt, occ_cnt_nxt, cap_r;
  logic [DUR_W-1:0]                exit_dur, exit_dur_r;
  logic                            free_any, exit_hit, entry_ok, entry_rej, exit_ok, exit_bad;
  logic                            full_r, entry_ack_r, entry_rej_r, exit_ack_r, exit_err_r;
  logic [0:0]                      state;
  logic [HOLD_W-1:0]               hold;

  // Allocation looks at pre-exit occupancy so a slot freed this cycle is never reassigned this cycle.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--)
      if (!occ[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    exit_hit = 1'b0;
    exit_dur = '0;
    for (int i = 0; i < NUM_SPOTS; i++)
      if (bus.exit_slot == IDX_W'(i) && occ[i]) begin
        exit_hit = 1'b1;
        exit_dur = dur[i];
      end
    entry_ok  = bus.entry_req && free_any;
    entry_rej = bus.entry_req && !free_any;
    exit_ok   = bus.exit_req && exit_hit;
    exit_bad  = bus.exit_req && !exit_hit;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      alloc[i] = entry_ok && (free_idx == IDX_W'(i));
      rel[i]   = exit_ok && (bus.exit_slot == IDX_W'(i));
    end
    occ_nxt = (occ & ~rel) | alloc;
    free_cnt_nxt = '0;
    loc_nxt      = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--)
      if (!occ_nxt[i]) begin
        free_cnt_nxt = free_cnt_nxt + CAP_W'(1);
        loc_nxt      = IDX_W'(i);
      end
    occ_cnt_nxt = CAP_W'(NUM_SPOTS) - free_cnt_nxt;
  end

  for (genvar g = 0; g < NUM_SPOTS; g++) begin : g_spot
    parking_spot_timer #(.DUR_W(DUR_W)) u_tmr (
      .clk   (clk),
      .reset (reset),
      .tick  (bus.tick),
      .keep  (occ_nxt[g]),
      .clr   (alloc[g]),
      .dur   (dur[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ          <= '0;
      cap_r        <= CAP_W'(NUM_SPOTS);
      loc_r        <= '0;
      full_r       <= 1'b0;
      entry_ack_r  <= 1'b0;
      entry_rej_r  <= 1'b0;
      exit_ack_r   <= 1'b0;
      exit_err_r   <= 1'b0;
      entry_slot_r <= '0;
      exit_dur_r   <= '0;
    end else begin
      occ         <= occ_nxt;
      cap_r       <= free_cnt_nxt;
      loc_r       <= loc_nxt;
      full_r      <= (free_cnt_nxt == '0);
      entry_ack_r <= entry_ok;
      entry_rej_r <= entry_rej;
      exit_ack_r  <= exit_ok;
      exit_err_r  <= exit_bad;
      if (entry_ok) entry_slot_r <= free_idx;
      if (exit_ok)  exit_dur_r   <= exit_dur;
    end
  end

  // An accepted event (re)loads the hold count; the tick that drains the last unit closes the door.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLOSED;
      hold  <= '0;
    end else if (entry_ok || exit_ok) begin
      state <= OPEN;
      hold  <= HOLD_W'(DOOR_HOLD);
    end else if (state == OPEN && bus.tick) begin
      if (hold <= HOLD_W'(1)) begin
        state <= CLOSED;
        hold  <= '0;
      end else begin
        hold <= hold - HOLD_W'(1);
      end
    end
  end

`ifdef PARK_STATS_EN
  logic [15:0]      total_r;
  logic [CAP_W-1:0] peak_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      total_r <= '0;
      peak_r  <= '0;
    end else begin
      if (entry_ok) total_r <= total_r + 16'd1;
      if (occ_cnt_nxt > peak_r) peak_r <= occ_cnt_nxt;
    end
  end
  assign bus.total_entries  = total_r;
  assign bus.peak_occupancy = peak_r;
`endif

  assign bus.spots         = occ;
  assign bus.capacity      = cap_r;
  assign bus.location      = loc_r;
  assign bus.is_full       = full_r;
  assign bus.is_open       = (state == OPEN);
  assign bus.entry_ack     = entry_ack_r;
  assign bus.entry_slot    = entry_slot_r;
  assign bus.entry_reject  = entry_rej_r;
  assign bus.exit_ack      = exit_ack_r;
  assign bus.exit_err      = exit_err_r;
  assign bus.exit_duration = exit_dur_r;
endmodule

// File: tb/tb_parking_ctrl_gen.sv
// Bench for parking_ctrl_gen: per-cycle model compare on two instances (DUR_W=12 and DUR_W=3) plus directed literals.
module tb_parking_ctrl_gen;
  localparam int N = 4, HOLD = 2, SMAX = 7;

  logic clk = 1'b0, reset = 1'b1;
  logic tick = 1'b0, entry_req = 1'b0, exit_req = 1'b0;
  logic [1:0] exit_slot = '0;
  int n_chk = 0, n_fail = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  parking_ctrl_gen_if #(.NUM_SPOTS(N), .DUR_W(12)) bus ();
  parking_ctrl_gen_if #(.NUM_SPOTS(N), .DUR_W(3))  bus_s ();

  assign bus.tick = tick;       assign bus_s.tick = tick;
  assign bus.entry_req = entry_req; assign bus_s.entry_req = entry_req;
  assign bus.exit_req = exit_req;   assign bus_s.exit_req = exit_req;
  assign bus.exit_slot = exit_slot; assign bus_s.exit_slot = exit_slot;

  parking_ctrl_gen #(.NUM_SPOTS(N), .DUR_W(12), .DOOR_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  parking_ctrl_gen #(.NUM_SPOTS(N), .DUR_W(3), .DOOR_HOLD(HOLD)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain per-spot occupancy and tick counts, door as remaining-ticks counter.
  bit m_occ[N];
  int m_dur[N];
  int m_left = 0, m_total = 0, m_peak = 0;
  bit m_open = 0;
  int x_ack_e = 0, x_slot = 0, x_rej = 0, x_ack_x = 0, x_err = 0, x_dur = 0;

  always @(posedge clk) begin : model
    int fi, cnt;
    bit xv;
    armed = 1'b1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_occ[i] = 0; m_dur[i] = 0; end
      m_open = 0; m_left = 0; m_total = 0; m_peak = 0;
      x_ack_e = 0; x_rej = 0; x_ack_x = 0; x_err = 0; x_slot = 0; x_dur = 0;
    end else begin
      fi = -1;
      for (int i = 0; i < N; i++) if (!m_occ[i] && fi < 0) fi = i;
      x_ack_e = int'(entry_req && fi >= 0);
      x_rej   = int'(entry_req && fi < 0);
      xv      = exit_req && m_occ[exit_slot];
      x_ack_x = int'(xv);
      x_err   = int'(exit_req && !xv);
      if (x_ack_e != 0) x_slot = fi;
      if (xv) begin
        x_dur = m_dur[exit_slot];
        m_occ[exit_slot] = 0;
        m_dur[exit_slot] = 0;
      end
      if (tick) for (int i = 0; i < N; i++) if (m_occ[i] && m_dur[i] < 4095) m_dur[i]++;
      if (x_ack_e != 0) begin
        m_occ[fi] = 1; m_dur[fi] = 0;
        m_total = (m_total + 1) % 65536;
      end
      if (x_ack_e != 0 || xv) begin m_open = 1; m_left = HOLD; end
      else if (m_open && tick) begin
        m_left--;
        if (m_left == 0) m_open = 0;
      end
      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(m_occ[i]);
      if (cnt > m_peak) m_peak = cnt;
    end
  end

  always @(negedge clk) begin : compare
    int bm, cap, loc;
    if (armed) begin
      bm = 0; cap = 0; loc = -1;
      for (int i = 0; i < N; i++) begin
        if (m_occ[i]) bm |= (1 << i);
        else begin cap++; if (loc < 0) loc = i; end
      end
      if (loc < 0) loc = 0;
      chk("spots", int'(bus.spots), bm);
      chk("capacity", int'(bus.capacity), cap);
      chk("location", int'(bus.location), loc);
      chk("is_full", int'(bus.is_full), int'(cap == 0));
      chk("is_open", int'(bus.is_open), int'(m_open));
      chk("entry_ack", int'(bus.entry_ack), x_ack_e);
      chk("entry_reject", int'(bus.entry_reject), x_rej);
      chk("exit_ack", int'(bus.exit_ack), x_ack_x);
      chk("exit_err", int'(bus.exit_err), x_err);
      chk("s_spots", int'(bus_s.spots), bm);
      chk("s_is_open", int'(bus_s.is_open), int'(m_open));
      chk("s_exit_ack", int'(bus_s.exit_ack), x_ack_x);
      if (x_ack_e != 0) chk("entry_slot", int'(bus.entry_slot), x_slot);
      if (x_ack_x != 0) begin
        chk("exit_duration", int'(bus.exit_duration), x_dur);
        chk("s_exit_duration", int'(bus_s.exit_duration), (x_dur > SMAX) ? SMAX : x_dur);
      end
`ifdef PARK_STATS_EN
      chk("total_entries", int'(bus.total_entries), m_total);
      chk("peak_occupancy", int'(bus.peak_occupancy), m_peak);
`endif
    end
  end

  // One request cycle; returns 1ns after the edge that registered the response.
  task automatic cyc(input bit e, input bit x, input int s, input bit t);
    entry_req = e; exit_req = x; exit_slot = 2'(s); tick = t;
    @(posedge clk); #1;
    entry_req = 0; exit_req = 0; tick = 0;
  endtask

  task automatic do_reset();
    reset = 1; @(posedge clk); #1; reset = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_spots", int'(bus.spots), 0);
    chk("rst_capacity", int'(bus.capacity), 4);
    chk("rst_location", int'(bus.location), 0);
    chk("rst_is_full", int'(bus.is_full), 0);
    chk("rst_is_open", int'(bus.is_open), 0);
    chk("rst_exit_duration", int'(bus.exit_duration), 0);

    // Fill the lot, then overflow.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      chk("fill_ack", int'(bus.entry_ack), 1);
      chk("fill_slot", int'(bus.entry_slot), i);
    end
    chk("full_spots", int'(bus.spots), 15);
    chk("full_capacity", int'(bus.capacity), 0);
    chk("full_is_full", int'(bus.is_full), 1);
    cyc(1, 0, 0, 0);
    chk("ovf_reject", int'(bus.entry_reject), 1);
    chk("ovf_ack", int'(bus.entry_ack), 0);
    chk("ovf_spots", int'(bus.spots), 15);
    chk("ovf_is_open", int'(bus.is_open), 1);

    // Exit from the middle, lowest free reused.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("mid_exit_ack", int'(bus.exit_ack), 1);
    chk("mid_spots", int'(bus.spots), 5);
    chk("mid_location", int'(bus.location), 1);
    cyc(1, 0, 0, 0);
    chk("reuse_slot", int'(bus.entry_slot), 1);

    // Reset with three cars parked and the door open.
    chk("pre_rst_open", int'(bus.is_open), 1);
    do_reset();
    chk("mrst_spots", int'(bus.spots), 0);
    chk("mrst_capacity", int'(bus.capacity), 4);
    chk("mrst_is_open", int'(bus.is_open), 0);
`ifdef PARK_STATS_EN
    chk("mrst_total", int'(bus.total_entries), 0);
    chk("mrst_peak", int'(bus.peak_occupancy), 0);
`endif

    // Duration counting and saturation.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("dur7", int'(bus.exit_duration), 7);
    chk("dur7_s", int'(bus_s.exit_duration), 7);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    chk("dur10", int'(bus.exit_duration), 10);
    chk("dur10_sat", int'(bus_s.exit_duration), 7);

    // Full lot with simultaneous entry and exit.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 2, 0);
    chk("sim_reject", int'(bus.entry_reject), 1);
    chk("sim_exit_ack", int'(bus.exit_ack), 1);
    chk("sim_spots", int'(bus.spots), 11);
    chk("sim_capacity", int'(bus.capacity), 1);
    chk("sim_location", int'(bus.location), 2);

    // Door timing.
    do_reset();
    cyc(0, 1, 3, 0);
    chk("err_exit", int'(bus.exit_err), 1);
    chk("err_is_open", int'(bus.is_open), 0);
    cyc(1, 0, 0, 0);
    chk("door_open", int'(bus.is_open), 1);
    cyc(0, 0, 0, 1);
    chk("door_t1", int'(bus.is_open), 1);
    cyc(0, 0, 0, 1);
    chk("door_t2", int'(bus.is_open), 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("reload_slot", int'(bus.entry_slot), 2);
    cyc(0, 0, 0, 1);
    chk("reload_t1", int'(bus.is_open), 1);
    cyc(0, 0, 0, 1);
    chk("reload_t2", int'(bus.is_open), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_ctrl_gen.md
Name: parking_ctrl_gen

Overview:
Parametrised parking-lot controller core; the next generation of the fixed 4-spot parking FSM. Supports NUM_SPOTS spots with lowest-free-slot allocation, per-spot parking-duration timers, a timed door-open state machine and explicit accept/reject/error reporting. Sits between the debounced entry/exit pulses and the display/LED drivers; all outputs are registered.

Parameters:
NUM_SPOTS, 4, number of parking spots (2..16)
DUR_W, 12, width of the per-spot duration counters in ticks; saturating
DOOR_HOLD, 3, number of tick pulses the door stays open after an accepted event (>=1)
IDX_W, $clog2(NUM_SPOTS), slot index width (localparam)
CAP_W, $clog2(NUM_SPOTS+1), free-count width (localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tick  in  1  one-cycle enable pulse, 1 Hz time base
entry_req  in  1  one-cycle pulse: car at entry
exit_req  in  1  one-cycle pulse: car leaving
exit_slot  in  IDX_W  slot index of the leaving car, sampled with exit_req
spots  out  NUM_SPOTS  occupancy bitmap, bit i = spot i occupied
capacity  out  CAP_W  number of free spots
location  out  IDX_W  lowest-index free spot; 0 when full
is_full  out  1  high when capacity == 0
is_open  out  1  door-open indication
entry_ack  out  1  pulse: entry accepted
entry_slot  out  IDX_W  slot assigned, valid with entry_ack
entry_reject  out  1  pulse: entry refused because lot full
exit_ack  out  1  pulse: exit accepted
exit_err  out  1  pulse: exit_slot empty or out of range
exit_duration  out  DUR_W  ticks the car was parked, valid with exit_ack

Behaviour:
- Reset (synchronous, active-high, overrides everything): spots=0, capacity=NUM_SPOTS, location=0, is_full=0, is_open=0, all pulses 0, entry_slot=0, exit_duration=0, all duration counters 0, door FSM CLOSED.
- Latency: every response appears one cycle after the request cycle; pulses last exactly one cycle.
- Entry: if any spot is free, allocate the lowest free index, set its bit, clear its duration counter, assert entry_ack with entry_slot. If full, assert entry_reject; state unchanged.
- Exit: if exit_slot < NUM_SPOTS and occupied, clear the bit, assert exit_ack, exit_duration = that spot's counter value. Otherwise exit_err; state unchanged.
- Simultaneous entry_req and exit_req: both processed. Allocation uses occupancy before the exit, so a slot freed this cycle is not reassigned this cycle; a full lot with a valid exit still rejects the entry. capacity reflects both (net unchanged when both accepted).
- capacity, location, is_full are derived from the registered bitmap and update in the same cycle as spots.
- Duration counters: on tick, each occupied spot's counter increments, saturating at 2^DUR_W-1. Free spots hold 0. A tick coinciding with allocation leaves the new spot at 0.
- Door FSM: CLOSED -> OPEN on any entry_ack or exit_ack, loading hold counter = DOOR_HOLD. In OPEN, each tick decrements; at 0 -> CLOSED. A further accepted event in OPEN reloads DOOR_HOLD. Rejects/errors never open the door. is_open = (state == OPEN).
- Reset mid-operation: all cars dropped, door closes on the next edge.

Optional Feature:
PARK_STATS_EN: when defined, adds outputs total_entries (16 bits, count of entry_ack, wraps at 65535->0) and peak_occupancy (CAP_W, maximum occupied count since reset), both reset to 0 and updated in the same cycle as spots. When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
NUM_SPOTS=4, DOOR_HOLD=2: reset, then 4 entry pulses -> entry_slot 0,1,2,3; spots=4'b1111, capacity=0, is_full=1; 5th entry -> entry_reject=1, spots unchanged, is_open stays as set by previous accepts.
Fill slots 0-2, exit_slot=1 -> exit_ack, spots=4'b0101, location=1; next entry -> entry_slot=1.
Park slot 0, apply 7 ticks, exit slot 0 -> exit_duration=7; DUR_W=3 with 10 ticks -> exit_duration=7 (saturated).
Full lot, entry_req and exit_req(slot 2) same cycle -> entry_reject=1, exit_ack=1, spots=4'b1011, capacity=1.
Exit on empty slot 3 -> exit_err=1, is_open unchanged; accepted entry then 1 tick -> is_open=1, second tick -> is_open=0; re-entry after 1 tick keeps door open 2 more ticks.
Reset asserted with 3 cars and door open -> next cycle spots=0, capacity=4, is_open=0; with PARK_STATS_EN total_entries=0, peak_occupancy=0.
